// File: rtl/datapath_pkg.sv
// Shared definitions for the bus-oriented datapath: word width, register count
// and the ALU operation encodings driven by the control unit.
package datapath_pkg;

    localparam int WORD_W  = 32;
    localparam int NUM_GPR = 16;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [2*WORD_W-1:0] dword_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A comes from Y, B from the bus; the 64-bit result feeds Z.
// Only MUL and DIV produce a non-zero upper half.
module alu
    import datapath_pkg::*;
(
    input  logic [WORD_W-1:0]   A,
    input  logic [WORD_W-1:0]   B,
    input  logic                Cin,
    input  logic [4:0]          opcode,
    output logic [2*WORD_W-1:0] C
);

    logic [4:0]         shamt;
    logic signed [63:0] prod;

    assign shamt = B[4:0];
    assign prod  = $signed({{WORD_W{A[WORD_W-1]}}, A}) * $signed({{WORD_W{B[WORD_W-1]}}, B});

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        C = '0;
        unique case (opcode)
            OP_ADD:  C[WORD_W-1:0] = A + B + {{(WORD_W-1){1'b0}}, Cin};
            OP_SUB:  C[WORD_W-1:0] = A - B;
            OP_AND:  C[WORD_W-1:0] = A & B;
            OP_OR:   C[WORD_W-1:0] = A | B;
            OP_SHR:  C[WORD_W-1:0] = A >> shamt;
            OP_SHRA: C[WORD_W-1:0] = $signed(A) >>> shamt;
            OP_SHL:  C[WORD_W-1:0] = A << shamt;
            // A shift by the full word width yields zero, which makes a rotate by 0 come out right.
            OP_ROR:  C[WORD_W-1:0] = (A >> shamt) | (A << (6'd32 - {1'b0, shamt}));
            OP_ROL:  C[WORD_W-1:0] = (A << shamt) | (A >> (6'd32 - {1'b0, shamt}));
            OP_MUL:  C = prod;
            OP_DIV: begin
                if (B != '0)
                    C = {$signed(A) % $signed(B), $signed(A) / $signed(B)};
            end
            OP_NEG:  C[WORD_W-1:0] = -B;
            OP_NOT:  C[WORD_W-1:0] = ~B;
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: register file, special registers and the bus mux,
// with strobes from an external control unit and the ALU result captured in Z.
module data_path
    import datapath_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              PCout,
    input  logic              MDRout,
    input  logic              Zhighout,
    input  logic              Zlowout,
    input  logic              R0out,
    input  logic              R2out,
    input  logic              R3out,
    input  logic              R4out,
    input  logic              R5out,
    input  logic              R6out,
    input  logic              R7out,
    input  logic              R0in,
    input  logic              R1in,
    input  logic              R2in,
    input  logic              R3in,
    input  logic              R4in,
    input  logic              R5in,
    input  logic              R6in,
    input  logic              R7in,
    input  logic              R8in,
    input  logic              R9in,
    input  logic              R10in,
    input  logic              R11in,
    input  logic              R12in,
    input  logic              R13in,
    input  logic              R14in,
    input  logic              R15in,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              MARin,
    input  logic              Yin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              IncPC,
    input  logic              ZHighIn,
    input  logic              ZLowIn,
    input  logic              Cin,
    input  logic [4:0]        opcode,
    input  logic [WORD_W-1:0] Mdatain,
    output logic [WORD_W-1:0] BusMuxOut
);

    word_t               r [NUM_GPR];
    word_t               pc, ir, mar, mdr, hi, lo, y;
    dword_t              z;
    dword_t              alu_c;
    word_t               bus;
    word_t               mdr_d;
    logic [NUM_GPR-1:0]  r_in;

    assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    always_comb begin
        // NOTE: combinational logic uses blocking assignments so each later branch sees the value just written.
        bus = '0;
        if      (MDRout)   bus = mdr;
        else if (PCout)    bus = pc;
        else if (Zhighout) bus = z[2*WORD_W-1:WORD_W];
        else if (Zlowout)  bus = z[WORD_W-1:0];
        else if (R0out)    bus = r[0];
        else if (R2out)    bus = r[2];
        else if (R3out)    bus = r[3];
        else if (R4out)    bus = r[4];
        else if (R5out)    bus = r[5];
        else if (R6out)    bus = r[6];
        else if (R7out)    bus = r[7];
    end

    assign BusMuxOut = bus;
    assign mdr_d     = Read ? Mdatain : bus;

    alu u_alu (
        .A      (y),
        .B      (bus),
        .Cin    (Cin),
        .opcode (opcode),
        .C      (alu_c)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            // NOTE: the register file is flop-based, so it can and must be cleared entry by entry; a RAM macro could not be.
            for (int i = 0; i < NUM_GPR; i++)
                r[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++)
                if (r_in[i])
                    r[i] <= bus;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            hi  <= '0;
            lo  <= '0;
            y   <= '0;
            z   <= '0;
        end else begin
            // An increment wins over a bus load when both arrive together.
            if (IncPC)
                pc <= pc + 1'b1;
            else if (PCin)
                pc <= bus;
            if (IRin)    ir  <= bus;
            if (MARin)   mar <= bus;
            if (MDRin)   mdr <= mdr_d;
            if (HIin)    hi  <= bus;
            if (LOin)    lo  <= bus;
            if (Yin)     y   <= bus;
            if (ZLowIn)  z[WORD_W-1:0]          <= alu_c[WORD_W-1:0];
            if (ZHighIn) z[2*WORD_W-1:WORD_W]   <= alu_c[2*WORD_W-1:WORD_W];
        end
    end

    // IR, MAR, HI, LO and the GPRs without a bus-out strobe are consumed outside this block.
    logic unused_state;
    assign unused_state = ^{ir, mar, hi, lo, r[1], r[8], r[9], r[10],
                            r[11], r[12], r[13], r[14], r[15]};

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: expected bus/register values are queued
// when an operation is driven and compared when the result is observed.
module tb_data_path;

    logic        clock, clear;
    logic        PCout, MDRout, Zhighout, Zlowout;
    logic [7:0]  r_out;
    logic [15:0] r_in;
    logic        PCin, IRin, MARin, Yin, HIin, LOin, MDRin, Read, IncPC;
    logic        ZHighIn, ZLowIn, Cin;
    logic [4:0]  opcode;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdr_model;

    data_path dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .R0out(r_out[0]), .R2out(r_out[2]), .R3out(r_out[3]), .R4out(r_out[4]),
        .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
        .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
        .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .MDRin(MDRin), .Read(Read), .IncPC(IncPC), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .Cin(Cin), .opcode(opcode), .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'(obs), 64'hDEAD_0000_0000_0000);
        end else begin
            e = sb.pop_front();
            check(e.tag, 64'(obs), 64'(e.value));
        end
    endtask

    task automatic idle();
        {PCout, MDRout, Zhighout, Zlowout} = '0;
        r_out = '0;
        r_in  = '0;
        {PCin, IRin, MARin, Yin, HIin, LOin, MDRin, Read, IncPC} = '0;
        {ZHighIn, ZLowIn, Cin} = '0;
        opcode = 5'b00000;
        clear  = 1'b0;
    endtask

    task automatic clk_step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_gpr(input int k, input logic [31:0] v);
        Mdatain = v; Read = 1'b1; MDRin = 1'b1;
        clk_step();
        MDRout = 1'b1; r_in[k] = 1'b1;
        clk_step();
        mdr_model = v;
    endtask

    task automatic observe_bus();
        #2;
        pop_check(BusMuxOut);
        idle();
    endtask

    task automatic read_gpr(input int k);
        r_out[k] = 1'b1;
        observe_bus();
    endtask

    // Y <= Ra ; Z <= Y op Rb (both halves)
    task automatic alu_op(input int ka, input int kb, input logic [4:0] op, input logic cin);
        r_out[ka] = 1'b1; Yin = 1'b1;
        clk_step();
        r_out[kb] = 1'b1; opcode = op; Cin = cin; ZLowIn = 1'b1; ZHighIn = 1'b1;
        clk_step();
    endtask

    task automatic read_z();
        Zhighout = 1'b1;
        observe_bus();
        Zlowout = 1'b1;
        observe_bus();
    endtask

    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic [4:0] op);
        logic [31:0] t;
        longint      p;
        int          q, rm;
        t = a;
        case (op)
            5'b00011: return {32'h0, a + b + {31'h0, cin}};
            5'b00100: return {32'h0, a - b};
            5'b00101: return {32'h0, a & b};
            5'b00110: return {32'h0, a | b};
            5'b00111: return {32'h0, a >> b[4:0]};
            5'b01000: begin
                for (int i = 0; i < int'(b[4:0]); i++) t = {t[31], t[31:1]};
                return {32'h0, t};
            end
            5'b01001: return {32'h0, a << b[4:0]};
            5'b01010: begin
                for (int i = 0; i < int'(b[4:0]); i++) t = {t[0], t[31:1]};
                return {32'h0, t};
            end
            5'b01011: begin
                for (int i = 0; i < int'(b[4:0]); i++) t = {t[30:0], t[31]};
                return {32'h0, t};
            end
            5'b01111: begin
                p = longint'(int'(a)) * longint'(int'(b));
                return p;
            end
            5'b10000: begin
                if (b == 32'h0) return 64'h0;
                q  = int'(a) / int'(b);
                rm = int'(a) % int'(b);
                return {rm, q};
            end
            5'b10001: return {32'h0, 32'h0 - b};
            5'b10010: return {32'h0, ~b};
            default:  return 64'h0;
        endcase
    endfunction

    logic [4:0] ops [15] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                             5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                             5'b10000, 5'b10001, 5'b10010, 5'b00000, 5'b11111};

    initial begin
        logic [31:0] a, b;
        logic [4:0]  op;
        logic        cin;
        logic [63:0] res;

        idle();
        Mdatain   = '0;
        mdr_model = '0;
        clear = 1'b1;
        clk_step();

        // Reset: scatter values into many registers, then clear.
        load_gpr(1, 32'hA5A5_0001);
        load_gpr(4, 32'h1234_5678);
        load_gpr(15, 32'hFFFF_0000);
        r_out[4] = 1'b1; PCin = 1'b1; IRin = 1'b1; MARin = 1'b1; Yin = 1'b1; HIin = 1'b1; LOin = 1'b1;
        clk_step();
        r_out[4] = 1'b1; opcode = 5'b10010; ZLowIn = 1'b1; ZHighIn = 1'b1;
        clk_step();
        clear = 1'b1; r_in[3] = 1'b1; IncPC = 1'b1; MDRin = 1'b1; Read = 1'b1; Mdatain = 32'h77;
        clk_step();
        #2;
        check("rst_bus", 64'(BusMuxOut), 64'h0);
        for (int i = 0; i < 16; i++) check($sformatf("rst_r%0d", i), 64'(dut.r[i]), 64'h0);
        check("rst_pc",  64'(dut.pc),  64'h0);
        check("rst_ir",  64'(dut.ir),  64'h0);
        check("rst_mar", 64'(dut.mar), 64'h0);
        check("rst_mdr", 64'(dut.mdr), 64'h0);
        check("rst_hi",  64'(dut.hi),  64'h0);
        check("rst_lo",  64'(dut.lo),  64'h0);
        check("rst_y",   64'(dut.y),   64'h0);
        check("rst_z",   dut.z,        64'h0);
        mdr_model = '0;

        // Register loads through MDR.
        load_gpr(4, 32'h12); push("ld_r4", 32'h12); read_gpr(4);
        load_gpr(3, 32'h14); push("ld_r3", 32'h14); read_gpr(3);
        load_gpr(7, 32'h18); push("ld_r7", 32'h18); read_gpr(7);

        // Fetch: IR load, then PC -> MAR with increment in the same step.
        Mdatain = 32'h2A1B_8000; Read = 1'b1; MDRin = 1'b1;
        clk_step();
        mdr_model = 32'h2A1B_8000;
        MDRout = 1'b1; IRin = 1'b1;
        clk_step();
        check("fetch_ir", 64'(dut.ir), 64'h2A1B_8000);
        push("fetch_old_pc", 32'h0);
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        #2;
        pop_check(BusMuxOut);
        clk_step();
        check("fetch_mar", 64'(dut.mar), 64'h0);
        push("fetch_pc_inc", 32'h1);
        PCout = 1'b1; observe_bus();
        // IncPC outranks PCin.
        r_out[4] = 1'b1; PCin = 1'b1; IncPC = 1'b1;
        clk_step();
        push("incpc_prio", 32'h2);
        PCout = 1'b1; observe_bus();

        // AND: R4 <= R3 & R7.
        r_out[3] = 1'b1; Yin = 1'b1;
        clk_step();
        r_out[7] = 1'b1; opcode = 5'b00101; ZLowIn = 1'b1;
        clk_step();
        Zlowout = 1'b1; r_in[4] = 1'b1;
        clk_step();
        push("and_r4", 32'h10);
        read_gpr(4);

        // MUL -6 * 4.
        load_gpr(5, 32'hFFFF_FFFA);
        load_gpr(6, 32'h4);
        alu_op(5, 6, 5'b01111, 1'b0);
        push("mul_hi", 32'hFFFF_FFFF); push("mul_lo", 32'hFFFF_FFE8);
        read_z();

        // DIV 7 / 2, then divide by zero clears Z.
        load_gpr(5, 32'h7);
        load_gpr(2, 32'h2);
        alu_op(5, 2, 5'b10000, 1'b0);
        push("div_rem", 32'h1); push("div_quo", 32'h3);
        read_z();
        load_gpr(2, 32'h0);
        alu_op(5, 2, 5'b10000, 1'b0);
        push("div0_hi", 32'h0); push("div0_lo", 32'h0);
        read_z();

        // Bus priority.
        push("prio_mdr_pc", mdr_model);
        MDRout = 1'b1; PCout = 1'b1; observe_bus();
        push("prio_pc_zlo", 32'h2);
        PCout = 1'b1; Zlowout = 1'b1; r_out[0] = 1'b1; observe_bus();
        push("prio_r2_r7", 32'h0);
        r_out[2] = 1'b1; r_out[7] = 1'b1; observe_bus();

        // ADD wrap and carry-in.
        load_gpr(5, 32'hFFFF_FFFF);
        load_gpr(6, 32'h1);
        alu_op(5, 6, 5'b00011, 1'b0);
        push("add_wrap_hi", 32'h0); push("add_wrap_lo", 32'h0);
        read_z();
        load_gpr(5, 32'h5);
        load_gpr(6, 32'h3);
        alu_op(5, 6, 5'b00011, 1'b1);
        push("add_cin_hi", 32'h0); push("add_cin_lo", 32'h9);
        read_z();

        // Randomised ALU operations against the reference model.
        for (int n = 0; n < 24; n++) begin
            a   = $urandom();
            b   = (n % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            op  = ops[n % 15];
            cin = 1'($urandom_range(0, 1));
            if (op == 5'b10000 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h3;
            load_gpr(3, a);
            load_gpr(6, b);
            alu_op(3, 6, op, cin);
            res = ref_alu(a, b, cin, op);
            push($sformatf("rnd%0d_op%0h_hi", n, op), res[63:32]);
            push($sformatf("rnd%0d_op%0h_lo", n, op), res[31:0]);
            read_z();
        end

        // Reset in the middle of an operation discards it.
        load_gpr(4, 32'hCAFE_F00D);
        r_out[4] = 1'b1; Yin = 1'b1; clear = 1'b1;
        clk_step();
        push("mid_rst_r4", 32'h0);
        read_gpr(4);
        check("mid_rst_y", 64'(dut.y), 64'h0);

        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
